// File: rtl/program_sequencer_if.sv
// Instruction-memory and datapath bundle for program_sequencer.
// master: sequencer side; slave: memory/datapath side.
interface program_sequencer_if;
  logic [3:0] instr_addr;
  logic       instr_rd;
  logic [7:0] instr_data;
  logic       acc_zero;
  logic       acc_carry;
  logic [2:0] alu_op;
  logic [3:0] reg_addr;
  logic [3:0] imm;
  logic       acc_we;
  logic       reg_we;

  modport master (
    output instr_addr, instr_rd,
    output alu_op, reg_addr, imm,
    output acc_we, reg_we,
    input  instr_data, acc_zero, acc_carry
  );

  modport slave (
    input  instr_addr, instr_rd,
    input  alu_op, reg_addr, imm,
    input  acc_we, reg_we,
    output instr_data, acc_zero, acc_carry
  );
endinterface

// File: rtl/program_sequencer.sv
// Accumulator-machine program sequencer: FETCH/DECODE/EXECUTE with
// step/pause, halt, and a saturating retired-instruction counter.
// Ports: clk, rst (sync, active-high), start/start_index, step_mode/step,
// bus (instr fetch + datapath strobes), busy/paused/halted/retired status.
module program_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] start_index,
  input  logic       step_mode,
  input  logic       step,
  program_sequencer_if.master bus,
  output logic       busy,
  output logic       paused,
  output logic       halted,
  output logic [7:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_PAUSE   = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] ret_q, ret_d;

  logic [3:0] op;
  logic [3:0] opnd;

  assign op   = ir_q[7:4];
  assign opnd = ir_q[3:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= 4'd0;
      ir_q    <= 8'd0;
      ret_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    ir_d           = ir_q;
    ret_d          = ret_q;
    bus.instr_addr = pc_q;
    bus.instr_rd   = 1'b0;
    bus.alu_op     = 3'd0;
    bus.reg_addr   = opnd;
    bus.imm        = opnd;
    bus.acc_we     = 1'b0;
    bus.reg_we     = 1'b0;
    busy           = 1'b0;
    paused         = 1'b0;
    halted         = 1'b0;

    case (state_q)
      S_IDLE, S_HALT: begin
        halted = (state_q == S_HALT);
        if (start) begin
          pc_d    = start_index;
          ret_d   = 8'd0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        busy         = 1'b1;
        bus.instr_rd = 1'b1;
        state_d      = S_DECODE;
      end
      S_DECODE: begin
        busy    = 1'b1;
        ir_d    = bus.instr_data;
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        busy    = 1'b1;
        pc_d    = pc_q + 4'd1;
        if (ret_q != 8'hFF) ret_d = ret_q + 8'd1;
        state_d = step_mode ? S_PAUSE : S_FETCH;
        case (op)
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
            bus.alu_op = op[2:0];
            bus.acc_we = 1'b1;
          end
          4'h6: begin
            bus.alu_op = 3'd0;
            bus.acc_we = 1'b1;
          end
          4'h7: bus.reg_we = 1'b1;
          4'h8: begin
            bus.alu_op = 3'd6;
            bus.acc_we = 1'b1;
          end
          4'h9: pc_d = opnd;
          4'hA: if (bus.acc_zero) pc_d = opnd;
          4'hB: if (bus.acc_carry) pc_d = opnd;
          4'hF: state_d = S_HALT;
          default: ;
        endcase
      end
      S_PAUSE: begin
        busy   = 1'b1;
        paused = 1'b1;
        // step outranks a coincident start; start is not decoded here
        if (step) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign retired = ret_q;

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Ports (name direction width meaning) SHALL be:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begin execution at start_index
- start_index  in  4  first program address
- step_mode  in  1  1 = pause after each retired instruction
- step  in  1  one-cycle pulse; resume from pause
- instr_addr  out  4  instruction memory address (= pc)
- instr_rd  out  1  instruction read strobe
- instr_data  in  8  {opcode[7:4], operand[3:0]}; valid the cycle after instr_rd
- acc_zero  in  1  datapath flag: accumulator == 0
- acc_carry  in  1  datapath flag: carry from last ALU op
- alu_op  out  3  0 pass-reg, 1 add, 2 sub, 3 and, 4 or, 5 xor, 6 pass-imm
- reg_addr  out  4  register-file index (= operand)
- imm  out  4  immediate (= operand)
- acc_we  out  1  accumulator write strobe
- reg_we  out  1  register write strobe (reg[reg_addr] <= acc)
- busy  out  1  high from FETCH through EXECUTE and in PAUSE
- paused  out  1  high in PAUSE
- halted  out  1  high in HALT
- retired  out  8  retired-instruction count

Function
REQ-003 States SHALL be IDLE, FETCH, DECODE, EXECUTE, PAUSE, HALT; the FSM SHALL be fully encoded, and any illegal encoding SHALL go to IDLE.
- REQ-004 IDLE: start=1 SHALL load pc <= start_index, clear retired, and go to FETCH. start in any other state SHALL be ignored.
- REQ-005 FETCH: instr_rd=1 and instr_addr=pc for exactly one cycle, then DECODE.
- REQ-006 DECODE: ir <= instr_data, then EXECUTE.
- REQ-007 EXECUTE SHALL last one cycle. Strobes SHALL be combinational from ir in EXECUTE only, and low in every other state.
- REQ-008 Opcode actions in EXECUTE SHALL be:
  - 0 NOP: no strobe.
  - 1..5 ADD/SUB/AND/OR/XOR Rn: alu_op=opcode, acc_we=1.
  - 6 LDA Rn: alu_op=0, acc_we=1.
  - 7 STA Rn: reg_we=1.
  - 8 LDI k: alu_op=6, acc_we=1.
  - 9 JMP a: pc <= a.
  - A JZ a: pc <= a if acc_zero, else pc+1.
  - B JC a: pc <= a if acc_carry, else pc+1.
  - C..E: treated as NOP.
  - F HLT: no strobe; go to HALT.
- REQ-009 Flags SHALL be sampled in the EXECUTE cycle.
- REQ-010 Non-jump instructions SHALL set pc <= pc+1, modulo 16 (15 wraps to 0).
- REQ-011 Every EXECUTE, including HLT, SHALL increment retired; retired saturates at 255.
- REQ-012 After EXECUTE (non-HLT): if step_mode=1, go to PAUSE; otherwise go to FETCH.
- REQ-013 Throughput SHALL be 3 cycles per instruction when step_mode=0.
- REQ-014 PAUSE: step=1 SHALL go to FETCH next cycle. step SHALL be ignored in every state other than PAUSE. Clearing step_mode while in PAUSE SHALL NOT resume; a step pulse is required.
- REQ-015 HALT SHALL hold until start=1, which behaves as in IDLE (reload pc, clear retired, FETCH).
- REQ-016 busy SHALL be 1 in FETCH, DECODE, EXECUTE and PAUSE, and 0 in IDLE and HALT.
- REQ-017 A start pulse coinciding with step in PAUSE: step SHALL win and start SHALL be ignored.

Reset
REQ-018 rst=1 SHALL, on the next rising edge, set state=IDLE, pc=0, ir=0, retired=0. All strobes, busy, paused and halted SHALL be 0. rst SHALL have priority over start and step in every state, including mid-instruction. A strobe due in the same cycle as rst SHALL still be asserted combinationally from the pre-reset EXECUTE state.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Linear program: start, start_index=0; ROM = 81 (LDI 1), 13 (ADD R3), 72 (STA R2), F0 (HLT).
  -> Strobes at cycles 3, 6, 9: acc_we/alu_op=6/imm=1; acc_we/alu_op=1/reg_addr=3; reg_we/reg_addr=2.
  -> Then halted=1, retired=4.
- Branch: start_index=5; ROM[5]=A9 (JZ 9), acc_zero=1.
  -> The next instr_addr is 9.
  -> Repeat with acc_zero=0: the next instr_addr is 6.
- Wrap: start_index=15, ROM[15]=00.
  -> The second fetch is at instr_addr=0.
- Step mode: step_mode=1, two NOPs.
  -> paused=1 after the first EXECUTE; no instr_rd while paused.
  -> A step pulse gives instr_rd on the next cycle. retired=1 before the step, 2 after.
- Reset mid-op: assert rst during DECODE.
  -> Next cycle: busy=0, instr_addr=0, retired=0.
  -> A start issued during a run is ignored (pc unchanged).
- Saturation: ROM[0]=90 (JMP 0) run for 300 instructions.
  -> retired=255 and holds; busy=1 throughout.
